// File: rtl/dmem_stream_reader_if.sv
// Bundles the command, dmem and stream signals of dmem_stream_reader.
// master: the reader's view; slave: the environment (CPU side, arbiter, memory, sink).
interface dmem_stream_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
);
  // Command / status
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic              abort;
  logic              busy;
  logic              done;

  // Shared data-memory port
  logic              dm_req;
  logic              dm_gnt;
  logic [ADDR_W-1:0] dm_a;
  logic [DATA_W-1:0] dm_rd;
  logic              dm_we;

  // Output word stream
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (
    input  start, base, len, abort,
    output busy, done,
    output dm_req, dm_a, dm_we,
    input  dm_gnt, dm_rd,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    output start, base, len, abort,
    input  busy, done,
    input  dm_req, dm_a, dm_we,
    output dm_gnt, dm_rd,
    input  out_data, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/dmem_stream_reader.sv
// Read-only dmem initiator: on start, walks len words from base and emits each
// word on a valid/ready stream. Shares the dmem port through dm_req/dm_gnt.
module dmem_stream_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  dmem_stream_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [LEN_W-1:0]  rem_q,   rem_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              valid_q, valid_d;
  logic              last_q,  last_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic consumed;    // held word leaves on this edge
  logic fetch;       // dmem word captured on this edge
  logic last_fetch;  // the word being fetched is the final one

  assign consumed   = valid_q & bus.out_ready;
  // The output slot must be empty or emptying, and the grant is only honoured
  // while we are actually requesting (RUN). Abort suppresses the fetch.
  assign fetch      = (state_q == RUN) & bus.dm_gnt & (~valid_q | bus.out_ready) & ~bus.abort;
  assign last_fetch = (rem_q == LEN_W'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (bus.abort && (state_q != IDLE)) begin
      // Cancel: drop any pending word, no completion pulse.
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Abort takes priority over a simultaneous start.
          if (bus.start && !bus.abort) begin
            addr_d = bus.base;
            rem_d  = bus.len;
            if (bus.len != '0) begin
              state_d = RUN;
              busy_d  = 1'b1;
            end else begin
              // Empty transfer completes immediately without streaming.
              done_d = 1'b1;
            end
          end
        end

        RUN: begin
          if (consumed) valid_d = 1'b0;
          if (fetch) begin
            data_d  = bus.dm_rd;
            valid_d = 1'b1;
            last_d  = last_fetch;
            addr_d  = addr_q + ADDR_W'(1);
            rem_d   = rem_q - LEN_W'(1);
            if (last_fetch) state_d = DRAIN;
          end
        end

        DRAIN: begin
          // Final word already fetched; wait for the sink to take it.
          if (consumed) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dm_req    = (state_q == RUN);
  assign bus.dm_a      = addr_q;
  assign bus.dm_we     = 1'b0;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;

endmodule
